seq_pattern_detector: RTL and testbench



---
 rtl/seq_patdet_pkg.sv | 46 ++++
 rtl/seq_pattern_detector_history.sv | 38 +++
 rtl/seq_pattern_detector.sv | 91 +++++++++
 tb/tb_seq_pattern_detector.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_patdet_pkg.sv
// Shared constants, configuration record and helpers for seq_pattern_detector.
// The cfg_mask field exists only when SEQ_PATDET_MASK_EN is defined.
package seq_patdet_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  // The configuration record is sized for the largest legal MAX_LEN, so one
  // typedef serves every instance. Unused upper bits are cut away by len_mask().
  localparam int PAT_LIMIT = 32;
  localparam int CFG_LEN_W = 6;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef struct packed {
    logic [PAT_LIMIT-1:0] pattern;
    logic [CFG_LEN_W-1:0] len;
    logic                 overlap;
`ifdef SEQ_PATDET_MASK_EN
    logic [PAT_LIMIT-1:0] mask;
`endif
  } patdet_cfg_t;

  function automatic patdet_cfg_t cfg_reset();
    patdet_cfg_t c;
    c         = '0;
    c.overlap = 1'b1;
`ifdef SEQ_PATDET_MASK_EN
    c.mask    = '1;
`endif
    return c;
  endfunction

  // Ones in the low len bit positions.
  function automatic logic [PAT_LIMIT-1:0] len_mask(input logic [CFG_LEN_W-1:0] len);
    logic [PAT_LIMIT-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_LIMIT; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_pattern_detector_history.sv
// Serial history window and saturating fill counter for seq_pattern_detector.
// Outputs are the look-ahead view: the window and fill as they become once bit_in is taken.
module seq_pattern_detector_history #(
  parameter int MAX_LEN = 8,
  parameter int FILL_W  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic               clr,
  input  logic               fill_clr,
  output logic [MAX_LEN-1:0] history,
  output logic [FILL_W-1:0]  fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  // The oldest bit of a MAX_LEN window is only ever seen together with the
  // incoming bit, so MAX_LEN-1 stored bits hold the whole visible history.
  logic [MAX_LEN-2:0] hist_q;
  logic [FILL_W-1:0]  fill_q;

  assign history = {hist_q, bit_in};
  assign fill    = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en) begin
      hist_q <= history[MAX_LEN-2:0];
      fill_q <= fill_clr ? '0 : fill;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector with saturating match counter.
// Define SEQ_PATDET_MASK_EN to add the cfg_mask input (0 = don't-care bit).
module seq_pattern_detector
  import seq_patdet_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
`ifdef SEQ_PATDET_MASK_EN
  input  logic [MAX_LEN-1:0] cfg_mask,
`endif
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic               in_bit,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               active
);

  patdet_cfg_t          cfg_q;
  logic [MAX_LEN-1:0]   hist_nxt;
  logic [LEN_W-1:0]     fill_nxt;
  logic [PAT_LIMIT-1:0] hist_ext;
  logic [PAT_LIMIT-1:0] cmp_mask;
  logic                 sample;
  logic                 hit;

  seq_pattern_detector_history #(
    .MAX_LEN (MAX_LEN),
    .FILL_W  (LEN_W)
  ) u_history (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (sample),
    .bit_in   (in_bit),
    .clr      (cfg_load),
    .fill_clr (hit && !cfg_q.overlap),
    .history  (hist_nxt),
    .fill     (fill_nxt)
  );

  assign active = (cfg_q.len != '0) && (cfg_q.len <= CFG_LEN_W'(MAX_LEN));

  // A load takes priority over a simultaneous data bit, which is dropped.
  assign sample = in_valid && !cfg_load;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    hist_ext                = '0;
    hist_ext[MAX_LEN-1:0]   = hist_nxt;
    cmp_mask                = len_mask(cfg_q.len);
`ifdef SEQ_PATDET_MASK_EN
    cmp_mask                = cmp_mask & cfg_q.mask;
`endif
    hit = sample && active
       && (CFG_LEN_W'(fill_nxt) >= cfg_q.len)
       && (((hist_ext ^ cfg_q.pattern) & cmp_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cfg_q       <= cfg_reset();
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      if (cfg_load) begin
        cfg_q.pattern <= PAT_LIMIT'(cfg_pattern);
        cfg_q.len     <= CFG_LEN_W'(cfg_len);
        cfg_q.overlap <= cfg_overlap;
`ifdef SEQ_PATDET_MASK_EN
        cfg_q.mask    <= PAT_LIMIT'(cfg_mask);
`endif
      end
      match <= hit;
      // Clear dominates; the counter holds at all-ones rather than wrapping.
      if (cnt_clr) begin
        match_count <= '0;
      end else if (hit && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector: directed scenarios plus random
// stimulus against a queue-based reference model of the detection rules.
module tb_seq_pattern_detector;
  import seq_patdet_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = len_w(MAX_LEN);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk         = 1'b0;
  logic               rstn        = 1'b0;
  logic               cfg_load    = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
`ifdef SEQ_PATDET_MASK_EN
  logic [MAX_LEN-1:0] cfg_mask    = '1;
`endif
  logic [LEN_W-1:0]   cfg_len     = '0;
  logic               cfg_overlap = 1'b1;
  logic               cnt_clr     = 1'b0;
  logic               in_valid    = 1'b0;
  logic               in_bit      = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               active;

  seq_pattern_detector #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
`ifdef SEQ_PATDET_MASK_EN
    .cfg_mask    (cfg_mask),
`endif
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .match       (match),
    .match_count (match_count),
    .active      (active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: remembers received bits and how many arrived since the
  // last load or non-overlapping match; a match is the last len bits equalling
  // the pattern (newest bit against pattern bit 0).
  logic [MAX_LEN-1:0] m_pat;
  logic [MAX_LEN-1:0] m_mask;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_q[$];
  int                 m_since;
  bit                 exp_match;
  int                 exp_count;

  function automatic bit m_active();
    return (m_len >= 1) && (m_len <= MAX_LEN);
  endfunction

  task automatic model_reset();
    m_pat     = '0;
    m_mask    = '1;
    m_len     = 0;
    m_ovl     = 1'b1;
    m_q.delete();
    m_since   = 0;
    exp_match = 1'b0;
    exp_count = 0;
  endtask

  task automatic model_step();
    bit hit;
    hit = 1'b0;
    if (!rstn) begin
      model_reset();
      return;
    end
    if (cfg_load) begin
      m_pat   = cfg_pattern;
      m_len   = int'(cfg_len);
      m_ovl   = cfg_overlap;
`ifdef SEQ_PATDET_MASK_EN
      m_mask  = cfg_mask;
`endif
      m_q.delete();
      m_since = 0;
    end else if (in_valid) begin
      m_q.push_back(in_bit);
      if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
      m_since++;
      if (m_active() && m_since >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++) begin
          if (m_mask[i] && (m_q[m_q.size() - 1 - i] != m_pat[i])) hit = 1'b0;
        end
        if (hit && !m_ovl) m_since = 0;
      end
    end
    exp_match = hit;
    if (cnt_clr) exp_count = 0;
    else if (hit && exp_count < CNT_MAX) exp_count++;
  endtask

  // One clock: inputs were set before the edge, outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("match", match, exp_match);
    check("match_count", match_count, exp_count);
    check("active", active, m_active());
    rstn     = 1'b1;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [MAX_LEN-1:0] p, input int len, input bit ovl,
                      input logic [MAX_LEN-1:0] msk);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
`ifdef SEQ_PATDET_MASK_EN
    cfg_mask    = msk;
`else
    if (msk == '0) $display("note: mask ignored in this build");
`endif
    tick();
  endtask

  task automatic send(input bit b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
  endtask

  int sat_seq[5] = '{1, 2, 3, 3, 3};

  initial begin
    model_reset();
    rstn = 1'b0;
    tick();
    check("rst_count", match_count, 0);
    check("rst_active", active, 0);

    // 101, overlapping: matches after bits 3 and 5
    load(8'b101, 3, 1'b1, 8'hFF);
    clear_cnt();
    send(1); send(0); send(1); send(0); send(1);
    check("ovl1_count", match_count, 2);

    // same stream, non-overlapping: single match
    load(8'b101, 3, 1'b0, 8'hFF);
    clear_cnt();
    send(1); send(0); send(1); send(0); send(1);
    check("ovl0_count", match_count, 1);

    // 110101 with a three-cycle gap between bits 3 and 4
    load(8'b110101, 6, 1'b1, 8'hFF);
    clear_cnt();
    send(1); send(1); send(0);
    repeat (3) tick();
    send(1); send(0); send(1);
    check("gap_count", match_count, 1);

    // reload mid-stream with a coincident bit: the bit is dropped
    load(8'b101, 3, 1'b1, 8'hFF);
    clear_cnt();
    send(1); send(0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    load(8'b101, 3, 1'b1, 8'hFF);
    send(0); send(1);
    check("reload_none", match_count, 0);
    send(1); send(0); send(1);
    check("reload_count", match_count, 1);

    // zero and oversize lengths never match
    load(8'b0, 0, 1'b1, 8'hFF);
    clear_cnt();
    repeat (4) send(0);
    check("len0_active", active, 0);
    load(8'hFF, 9, 1'b1, 8'hFF);
    repeat (10) send(1);
    check("len9_count", match_count, 0);

    // counter saturation at 2^CNT_W-1
    load(8'b1, 1, 1'b1, 8'hFF);
    clear_cnt();
    for (int i = 0; i < 5; i++) begin
      send(1);
      check("sat_count", match_count, sat_seq[i]);
    end
    cnt_clr  = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    check("clr_dominates", match_count, 0);

    // masked middle bit: 1x1
    load(8'b101, 3, 1'b0, 8'b101);
    clear_cnt();
    send(1); send(1); send(1);
    send(1); send(0); send(1);
`ifdef SEQ_PATDET_MASK_EN
    check("mask_count", match_count, 2);
`else
    check("mask_count", match_count, 1);
`endif

    // reset mid-stream drops the configuration
    load(8'b101, 3, 1'b1, 8'hFF);
    send(1); send(0);
    rstn     = 1'b0;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    check("midrst_active", active, 0);
    send(1); send(0); send(1);
    check("midrst_count", match_count, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        int r;
        int len;
        r = int'($urandom_range(0, 99));
        if (r < 5)       len = 0;
        else if (r < 10) len = int'($urandom_range(MAX_LEN + 1, (1 << LEN_W) - 1));
        else if (r < 60) len = int'($urandom_range(1, 3));
        else             len = int'($urandom_range(1, MAX_LEN));
        cfg_load    = 1'b1;
        cfg_pattern = MAX_LEN'($urandom);
        cfg_len     = LEN_W'(len);
        cfg_overlap = 1'($urandom_range(0, 1));
`ifdef SEQ_PATDET_MASK_EN
        cfg_mask    = MAX_LEN'($urandom);
`endif
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_bit   = 1'($urandom_range(0, 1));
      cnt_clr  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0) rstn = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
